// File: rtl/udp_plus_fix.sv
// Streaming UDP + FIX 4.4 ingress parser: strips the 8-byte UDP header, tokenises
// tag=value fields and emits one decoded order per FIX message on registered outputs.
module udp_plus_fix #(
    parameter int SYM_BYTES  = 6,
    parameter int PRICE_FRAC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_in,
    input  logic                   valid_in,
    output logic                   fix_packet_done_in,
    output logic                   msg_valid,
    output logic                   msg_type,
    output logic [8*SYM_BYTES-1:0] symbol_id,
    output logic                   side,
    output logic [63:0]            price,
    output logic [63:0]            quantity,
    output logic [31:0]            order_id
);

    localparam int SW  = 8 * SYM_BYTES;
    localparam int SCW = $clog2(SYM_BYTES + 1);
    localparam int FW  = $clog2(PRICE_FRAC + 1);

    typedef enum logic [1:0] {HDR, TAG, VAL} state_e;

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       lenHi_q, lenHi_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      tag_q, tag_d;
    logic             firstChar_q, firstChar_d;
    logic [63:0]      acc_q, acc_d;
    logic             fracOn_q, fracOn_d;
    logic [FW-1:0]    fracCnt_q, fracCnt_d;
    logic             typeOk_q, typeOk_d;
    logic             type_q, type_d;
    logic [SW-1:0]    sym_q, sym_d;
    logic [SCW-1:0]   symCnt_q, symCnt_d;
    logic             side_q, side_d;
    logic [63:0]      price_q, price_d;
    logic [63:0]      qty_q, qty_d;
    logic [31:0]      ordId_q, ordId_d;

    logic             msgValid_q, msgValid_d;
    logic             done_q, done_d;
    logic             outType_q, outType_d;
    logic [SW-1:0]    outSym_q, outSym_d;
    logic             outSide_q, outSide_d;
    logic [63:0]      outPrice_q, outPrice_d;
    logic [63:0]      outQty_q, outQty_d;
    logic [31:0]      outOrdId_q, outOrdId_d;

    logic             isDigit;
    logic             lastByte;
    logic             msgEnd;
    logic             clearMsg;
    logic [63:0]      digitVal;

    // Multiplier that brings a price with fd fraction digits up to PRICE_FRAC places.
    function automatic logic [63:0] fracScale(input logic [FW-1:0] fd);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < PRICE_FRAC; i++) begin
            if (i >= int'(fd)) p = p * 64'd10;
        end
        return p;
    endfunction

    assign isDigit  = (data_in >= 8'h30) && (data_in <= 8'h39);
    assign digitVal = {60'd0, data_in[3:0]};
    // The header alone ends the datagram when its length field is 8 or less.
    assign lastByte = (state_q == HDR) ? ((cnt_q == 16'd7) && (len_q <= 16'd8))
                                       : ((cnt_q + 16'd1) == len_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lenHi_d     = lenHi_q;
        len_d       = len_q;
        tag_d       = tag_q;
        firstChar_d = firstChar_q;
        acc_d       = acc_q;
        fracOn_d    = fracOn_q;
        fracCnt_d   = fracCnt_q;
        typeOk_d    = typeOk_q;
        type_d      = type_q;
        sym_d       = sym_q;
        symCnt_d    = symCnt_q;
        side_d      = side_q;
        price_d     = price_q;
        qty_d       = qty_q;
        ordId_d     = ordId_q;
        msgValid_d  = 1'b0;
        done_d      = 1'b0;
        outType_d   = outType_q;
        outSym_d    = outSym_q;
        outSide_d   = outSide_q;
        outPrice_d  = outPrice_q;
        outQty_d    = outQty_q;
        outOrdId_d  = outOrdId_q;
        msgEnd      = 1'b0;
        clearMsg    = 1'b0;

        if (valid_in) begin
            cnt_d = cnt_q + 16'd1;
            unique case (state_q)
                HDR: begin
                    if (cnt_q == 16'd4) lenHi_d = data_in;
                    if (cnt_q == 16'd5) len_d = {lenHi_q, data_in};
                    if (cnt_q == 16'd7) state_d = TAG;
                end
                TAG: begin
                    if (isDigit) begin
                        tag_d = tag_q * 16'd10 + {12'd0, data_in[3:0]};
                    end else if (data_in == 8'h3D) begin
                        state_d     = VAL;
                        acc_d       = 64'd0;
                        fracOn_d    = 1'b0;
                        fracCnt_d   = '0;
                        firstChar_d = 1'b1;
                        if (tag_q == 16'd55) begin
                            sym_d    = '0;
                            symCnt_d = '0;
                        end
                    end else if (data_in == 8'h01) begin
                        tag_d = 16'd0;
                    end
                end
                VAL: begin
                    if (data_in == 8'h01) begin
                        state_d = TAG;
                        tag_d   = 16'd0;
                        case (tag_q)
                            16'd44:  price_d = acc_q * fracScale(fracCnt_q);
                            16'd38:  qty_d   = acc_q;
                            16'd11:  ordId_d = acc_q[31:0];
                            16'd10:  msgEnd  = 1'b1;
                            default: ;
                        endcase
                    end else begin
                        firstChar_d = 1'b0;
                        case (tag_q)
                            16'd35: begin
                                if (firstChar_q) begin
                                    typeOk_d = (data_in == 8'h44) || (data_in == 8'h46);
                                    type_d   = (data_in == 8'h46);
                                end
                            end
                            16'd54: begin
                                if (firstChar_q) side_d = (data_in == 8'h32);
                            end
                            16'd55: begin
                                if (symCnt_q < SCW'(SYM_BYTES)) begin
                                    sym_d[(SYM_BYTES - 1 - int'(symCnt_q)) * 8 +: 8] = data_in;
                                    symCnt_d = symCnt_q + SCW'(1);
                                end
                            end
                            16'd44: begin
                                if (isDigit) begin
                                    if (!fracOn_q) begin
                                        acc_d = acc_q * 64'd10 + digitVal;
                                    end else if (fracCnt_q < FW'(PRICE_FRAC)) begin
                                        acc_d     = acc_q * 64'd10 + digitVal;
                                        fracCnt_d = fracCnt_q + FW'(1);
                                    end
                                end else if (data_in == 8'h2E) begin
                                    fracOn_d = 1'b1;
                                end
                            end
                            16'd38, 16'd11: begin
                                if (isDigit) acc_d = acc_q * 64'd10 + digitVal;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = HDR;
            endcase

            if (msgEnd) begin
                clearMsg = 1'b1;
                if (typeOk_q) begin
                    msgValid_d = 1'b1;
                    outType_d  = type_q;
                    outSym_d   = sym_q;
                    outSide_d  = side_q;
                    outPrice_d = price_q;
                    outQty_d   = qty_q;
                    outOrdId_d = ordId_q;
                end
            end

            // Datagram end wins over everything else and drops any partial message.
            if (lastByte) begin
                state_d  = HDR;
                cnt_d    = 16'd0;
                done_d   = 1'b1;
                clearMsg = 1'b1;
            end
        end

        if (clearMsg) begin
            tag_d       = 16'd0;
            acc_d       = 64'd0;
            fracOn_d    = 1'b0;
            fracCnt_d   = '0;
            firstChar_d = 1'b0;
            typeOk_d    = 1'b0;
            type_d      = 1'b0;
            sym_d       = '0;
            symCnt_d    = '0;
            side_d      = 1'b0;
            price_d     = 64'd0;
            qty_d       = 64'd0;
            ordId_d     = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            cnt_q       <= 16'd0;
            lenHi_q     <= 8'd0;
            len_q       <= 16'd0;
            tag_q       <= 16'd0;
            firstChar_q <= 1'b0;
            acc_q       <= 64'd0;
            fracOn_q    <= 1'b0;
            fracCnt_q   <= '0;
            typeOk_q    <= 1'b0;
            type_q      <= 1'b0;
            sym_q       <= '0;
            symCnt_q    <= '0;
            side_q      <= 1'b0;
            price_q     <= 64'd0;
            qty_q       <= 64'd0;
            ordId_q     <= 32'd0;
            msgValid_q  <= 1'b0;
            done_q      <= 1'b0;
            outType_q   <= 1'b0;
            outSym_q    <= '0;
            outSide_q   <= 1'b0;
            outPrice_q  <= 64'd0;
            outQty_q    <= 64'd0;
            outOrdId_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lenHi_q     <= lenHi_d;
            len_q       <= len_d;
            tag_q       <= tag_d;
            firstChar_q <= firstChar_d;
            acc_q       <= acc_d;
            fracOn_q    <= fracOn_d;
            fracCnt_q   <= fracCnt_d;
            typeOk_q    <= typeOk_d;
            type_q      <= type_d;
            sym_q       <= sym_d;
            symCnt_q    <= symCnt_d;
            side_q      <= side_d;
            price_q     <= price_d;
            qty_q       <= qty_d;
            ordId_q     <= ordId_d;
            msgValid_q  <= msgValid_d;
            done_q      <= done_d;
            outType_q   <= outType_d;
            outSym_q    <= outSym_d;
            outSide_q   <= outSide_d;
            outPrice_q  <= outPrice_d;
            outQty_q    <= outQty_d;
            outOrdId_q  <= outOrdId_d;
        end
    end

    assign fix_packet_done_in = done_q;
    assign msg_valid          = msgValid_q;
    assign msg_type           = outType_q;
    assign symbol_id          = outSym_q;
    assign side               = outSide_q;
    assign price              = outPrice_q;
    assign quantity           = outQty_q;
    assign order_id           = outOrdId_q;

endmodule

// File: tb/tb_udp_plus_fix.sv
// Randomised bench for udp_plus_fix: datagrams are decoded field-by-field by a
// string-level reference model and the DUT outputs are compared every cycle.
module tb_udp_plus_fix;

    typedef struct packed {
        logic        mtype;
        logic [47:0] sym;
        logic        side;
        logic [63:0] price;
        logic [63:0] qty;
        logic [31:0] oid;
    } order_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = 8'd0;
    logic        valid_in = 1'b0;
    logic        fix_packet_done_in;
    logic        msg_valid;
    logic        msg_type;
    logic [47:0] symbol_id;
    logic        side;
    logic [63:0] price;
    logic [63:0] quantity;
    logic [31:0] order_id;

    int          checks = 0;
    int          errors = 0;
    order_t      expHeld = '0;
    logic [7:0]  dg[$];
    bit          expMv[$];
    order_t      expOrd[$];
    order_t      mMsg;
    bit          mOk;

    udp_plus_fix #(.SYM_BYTES(6), .PRICE_FRAC(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .data_in            (data_in),
        .valid_in           (valid_in),
        .fix_packet_done_in (fix_packet_done_in),
        .msg_valid          (msg_valid),
        .msg_type           (msg_type),
        .symbol_id          (symbol_id),
        .side               (side),
        .price              (price),
        .quantity           (quantity),
        .order_id           (order_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, then compare every output after the clock edge has settled.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input bit mv,
                                 input bit done, input order_t ord);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        @(negedge clk);
        if (mv) expHeld = ord;
        checkOutput("msg_valid", 64'(msg_valid), 64'(mv));
        checkOutput("fix_packet_done", 64'(fix_packet_done_in), 64'(done));
        checkOutput("msg_type", 64'(msg_type), 64'(expHeld.mtype));
        checkOutput("symbol_id", 64'(symbol_id), 64'(expHeld.sym));
        checkOutput("side", 64'(side), 64'(expHeld.side));
        checkOutput("price", price, expHeld.price);
        checkOutput("quantity", quantity, expHeld.qty);
        checkOutput("order_id", 64'(order_id), 64'(expHeld.oid));
    endtask

    task automatic doReset();
        rst = 1'b1;
        expHeld = '0;
        repeat (2) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    function automatic logic [63:0] decimalOf(input string s);
        logic [63:0] v = 64'd0;
        for (int k = 0; k < s.len(); k++)
            if (s[k] >= "0" && s[k] <= "9") v = v * 64'd10 + 64'(s[k] - "0");
        return v;
    endfunction

    // Integer part times 10^4 plus the first four fraction digits, right-padded.
    function automatic logic [63:0] priceOf(input string s);
        logic [63:0] ip = 64'd0;
        logic [63:0] fv = 64'd0;
        int nf = 0;
        bit dot = 0;
        for (int k = 0; k < s.len(); k++) begin
            if (s[k] == ".") dot = 1;
            else if (s[k] >= "0" && s[k] <= "9") begin
                if (!dot) ip = ip * 64'd10 + 64'(s[k] - "0");
                else if (nf < 4) begin
                    fv = fv * 64'd10 + 64'(s[k] - "0");
                    nf++;
                end
            end
        end
        for (int k = nf; k < 4; k++) fv = fv * 64'd10;
        return ip * 64'd10000 + fv;
    endfunction

    // Apply one complete "tag=value" field to the message being modelled; returns 1 on tag 10.
    function automatic bit applyField(input string f);
        int eq = -1;
        int tagv;
        string val;
        for (int k = 0; k < f.len(); k++) if (f[k] == "=" && eq < 0) eq = k;
        if (eq < 1) return 0;
        tagv = f.substr(0, eq - 1).atoi();
        val  = (eq + 1 < f.len()) ? f.substr(eq + 1, f.len() - 1) : "";
        case (tagv)
            35: if (val.len() > 0) begin
                mOk = (val[0] == "D") || (val[0] == "F");
                mMsg.mtype = (val[0] == "F");
            end
            55: begin
                mMsg.sym = '0;
                for (int k = 0; k < 6 && k < val.len(); k++) mMsg.sym[47 - 8 * k -: 8] = val[k];
            end
            54: if (val.len() > 0) mMsg.side = (val[0] == "2");
            44: mMsg.price = priceOf(val);
            38: mMsg.qty = decimalOf(val);
            11: mMsg.oid = decimalOf(val)[31:0];
            default: ;
        endcase
        return tagv == 10;
    endfunction

    task automatic modelDatagram();
        string field = "";
        mMsg = '0;
        mOk  = 0;
        expMv.delete();
        expOrd.delete();
        for (int i = 0; i < dg.size(); i++) begin
            bit mv = 0;
            order_t snap = '0;
            if (i >= 8) begin
                if (dg[i] == 8'h01) begin
                    if (applyField(field)) begin
                        if (mOk) begin
                            mv = 1;
                            snap = mMsg;
                        end
                        mMsg = '0;
                        mOk  = 0;
                    end
                    field = "";
                end else begin
                    field = $sformatf("%s%c", field, dg[i]);
                end
            end
            expMv.push_back(mv);
            expOrd.push_back(snap);
        end
    endtask

    // cutLen < 0 sends the whole payload; abortAt >= 0 stops after that many bytes.
    task automatic sendDatagram(input string payload, input int cutLen, input int gapPct, input int abortAt);
        int total = 8 + payload.len();
        int lenField = (cutLen < 0) ? total : cutLen;
        int n = (lenField < 8) ? 8 : lenField;
        int stop;
        dg.delete();
        repeat (4) dg.push_back(8'($urandom));
        dg.push_back(8'(lenField >> 8));
        dg.push_back(8'(lenField));
        repeat (2) dg.push_back(8'($urandom));
        for (int i = 0; i < payload.len(); i++)
            dg.push_back((payload[i] == "|") ? 8'h01 : payload[i]);
        while (dg.size() > n) void'(dg.pop_back());
        modelDatagram();
        stop = (abortAt >= 0) ? abortAt : dg.size();
        for (int i = 0; i < stop; i++) begin
            while (int'($urandom_range(0, 99)) < gapPct)
                applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, '0);
            applyStimulus(1'b1, dg[i], expMv[i], (i == dg.size() - 1), expOrd[i]);
        end
    endtask

    function automatic string randDigits(input int n);
        string s = "";
        for (int k = 0; k < n; k++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
        return s;
    endfunction

    function automatic string randMsg();
        int t = $urandom_range(0, 9);
        string s = "8=FIX.4.4|35=";
        string sym = "";
        repeat ($urandom_range(1, 8)) sym = {sym, $sformatf("%c", $urandom_range(65, 90))};
        s = {s, (t < 4) ? "D" : (t < 8) ? "F" : "0", "|49=SNDR|11=", randDigits($urandom_range(1, 12)), "|"};
        s = {s, "55=", sym, "|54=", ($urandom_range(0, 1) != 0) ? "2" : "1", "|44=", randDigits($urandom_range(1, 5))};
        if ($urandom_range(0, 2) != 0) s = {s, ".", randDigits($urandom_range(0, 6))};
        s = {s, "|38=", randDigits($urandom_range(1, 7)), "|10=", randDigits(3), "|"};
        return s;
    endfunction

    initial begin
        string p1 = "8=FIX.4.4|35=D|11=1234|55=AAPL|54=1|44=187.25|38=100|10=045|";
        string p2 = "8=FIX.4.4|35=F|11=1234|55=AAPL|54=2|44=50|38=100|10=045|";
        string p3 = "8=FIX.4.4|35=D|11=77|55=MSFTXYZ|54=2|44=0.123456|38=5|10=001|";
        string pu = "8=FIX.4.4|35=0|112=TEST|10=010|";

        doReset();
        repeat (3) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, '0);

        sendDatagram(p1, -1, 0, -1);
        checkOutput("plan_type", 64'(msg_type), 64'd0);
        checkOutput("plan_oid", 64'(order_id), 64'd1234);
        checkOutput("plan_sym", 64'(symbol_id), 64'h4141504C0000);
        checkOutput("plan_side", 64'(side), 64'd0);
        checkOutput("plan_price", price, 64'd1872500);
        checkOutput("plan_qty", quantity, 64'd100);

        sendDatagram(p2, -1, 40, -1);
        checkOutput("plan_cancel_type", 64'(msg_type), 64'd1);
        checkOutput("plan_cancel_side", 64'(side), 64'd1);
        checkOutput("plan_cancel_price", price, 64'd500000);

        sendDatagram({p1, p2}, -1, 0, -1);
        sendDatagram(p3, -1, 0, -1);
        checkOutput("plan_sym_trunc", 64'(symbol_id), 64'h4D5346545859);
        checkOutput("plan_frac_trunc", price, 64'd1234);

        sendDatagram(pu, -1, 10, -1);
        sendDatagram(p1, 8 + 40, 10, -1);
        checkOutput("plan_held_price", price, 64'd1234);

        sendDatagram("", 3, 0, -1);
        sendDatagram("", 8, 0, -1);

        sendDatagram(p1, -1, 0, 20);
        doReset();
        sendDatagram(p2, -1, 0, -1);
        checkOutput("plan_after_reset", price, 64'd500000);

        for (int d = 0; d < 30; d++) begin
            string pay = "";
            int cut = -1;
            repeat ($urandom_range(1, 3)) pay = {pay, randMsg()};
            if ($urandom_range(0, 4) == 0) cut = $urandom_range(8, 8 + pay.len());
            sendDatagram(pay, cut, $urandom_range(0, 40), -1);
        end
        repeat (3) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
